tft_window_timing: RTL and testbench

- Timing and window-request generator for the 800x480 RGB565 TFT panel.
- Runs H/V counters and emits one-hot window requests with window-local x/y coordinates to the pixel-source mux.
- Samples the mux's display_data and drives panel hsync/vsync/DE/RGB, aligned for the source's read latency.
- Sits between the pixel-source mux and the panel pins; it is the requesting end of the tft_req / hcount / vcount / display_data interface.

---
 rtl/tft_pkg.sv | 71 +++++++
 rtl/tft_sync_delay.sv | 47 ++++
 rtl/tft_window_timing.sv | 179 +++++++++++++++++
 tb/tb_tft_window_timing.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared types, colour constants and default 800x480 timing for the TFT window timing block.
package tft_pkg;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
  } win_rect_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [10:0] x;
  } sync_bus_t;

  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t PURPPLE = 16'hF81F;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t WHITE   = 16'hFFFF;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned H_FP_DEF     = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BP_DEF     = 88;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Idle level of the panel-side pipeline: syncs are active low.
  localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, x: 11'd0};

  function automatic win_rect_t make_rect(int unsigned x, int unsigned y, int unsigned w,
                                          int unsigned h);
    win_rect_t r;
    r.x = 11'(x);
    r.y = 11'(y);
    r.w = 11'(w);
    r.h = 11'(h);
    return r;
  endfunction

  // Sums are taken at 12 bits so a window reaching past 2047 cannot wrap.
  function automatic logic in_rect(logic [10:0] px, logic [10:0] py, win_rect_t r);
    return (px >= r.x) && ({1'b0, px} < ({1'b0, r.x} + {1'b0, r.w})) &&
           (py >= r.y) && ({1'b0, py} < ({1'b0, r.y} + {1'b0, r.h}));
  endfunction

  function automatic rgb565_t bar_colour(logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return PURPPLE;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tft_sync_delay.sv
// Fixed-depth shift register carrying the panel sync bundle so it lines up with the RGB path.
module tft_sync_delay
  import tft_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic        fs_i,
  input  logic [10:0] x_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic        fs_o,
  output logic [10:0] x_o
);

  sync_bus_t              stage_in;
  sync_bus_t [Depth-1:0]  stage_q;

  always_comb begin
    stage_in    = SYNC_IDLE;
    stage_in.hs = hs_i;
    stage_in.vs = vs_i;
    stage_in.de = de_i;
    stage_in.fs = fs_i;
    stage_in.x  = x_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {Depth{SYNC_IDLE}};
    end else begin
      stage_q <= {stage_q[Depth-2:0], stage_in};
    end
  end

  assign hs_o = stage_q[Depth-1].hs;
  assign vs_o = stage_q[Depth-1].vs;
  assign de_o = stage_q[Depth-1].de;
  assign fs_o = stage_q[Depth-1].fs;
  assign x_o  = stage_q[Depth-1].x;

endmodule

// File: rtl/tft_window_timing.sv
// TFT H/V timing, one-hot window requests and latency-aligned panel outputs.
// Define TFT_TEST_PATTERN_EN to replace display_data with eight vertical colour bars.
module tft_window_timing
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned WIN0_X   = 0,
  parameter int unsigned WIN0_Y   = 0,
  parameter int unsigned WIN0_W   = 48,
  parameter int unsigned WIN0_H   = 16,
  parameter int unsigned WIN1_X   = 0,
  parameter int unsigned WIN1_Y   = 16,
  parameter int unsigned WIN1_W   = 32,
  parameter int unsigned WIN1_H   = 24,
  parameter int unsigned WIN2_X   = 64,
  parameter int unsigned WIN2_Y   = 64,
  parameter int unsigned WIN2_W   = 8,
  parameter int unsigned WIN2_H   = 16,
  parameter int unsigned WIN3_X   = 0,
  parameter int unsigned WIN3_Y   = 128,
  parameter int unsigned WIN3_W   = 800,
  parameter int unsigned WIN3_H   = 352,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [15:0] display_data,
  output logic [3:0]  tft_req,
  output logic [10:0] hcount_win,
  output logic [10:0] vcount_win,
  output logic        tft_hs,
  output logic        tft_vs,
  output logic        tft_de,
  output logic [15:0] tft_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HAct    = 11'(H_ACTIVE);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam win_rect_t [3:0] Win = {make_rect(WIN3_X, WIN3_Y, WIN3_W, WIN3_H),
                                     make_rect(WIN2_X, WIN2_Y, WIN2_W, WIN2_H),
                                     make_rect(WIN1_X, WIN1_Y, WIN1_W, WIN1_H),
                                     make_rect(WIN0_X, WIN0_Y, WIN0_W, WIN0_H)};

  logic [10:0] h_q, h_d, v_q, v_d;
  logic        active;
  logic [3:0]  hit;
  logic [1:0]  sel;
  logic [3:0]  req_d, req_q;
  logic [10:0] hwin_d, hwin_q, vwin_d, vwin_q;
  logic        hs_raw, vs_raw, fs_raw;
  logic        hs_dly, vs_dly, de_dly, fs_dly;
  logic [10:0] x_dly;

  always_comb begin
    h_d = (h_q == HLast) ? 11'd0 : h_q + 11'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      v_d = (v_q == VLast) ? 11'd0 : v_q + 11'd1;
    end
  end

  // Restricting hits to the active area is what clips windows that overhang it.
  always_comb begin
    active = (h_q < HAct) && (v_q < VAct);
    hit    = {in_rect(h_q, v_q, Win[3]), in_rect(h_q, v_q, Win[2]),
              in_rect(h_q, v_q, Win[1]), in_rect(h_q, v_q, Win[0])} & {4{active}};
    if (hit[0])      sel = 2'd0;
    else if (hit[1]) sel = 2'd1;
    else if (hit[2]) sel = 2'd2;
    else             sel = 2'd3;
    req_d  = 4'd0;
    hwin_d = 11'd0;
    vwin_d = 11'd0;
    if (|hit) begin
      req_d  = 4'b0001 << sel;
      hwin_d = h_q - Win[sel].x;
      vwin_d = v_q - Win[sel].y;
    end
  end

  always_comb begin
    hs_raw = !((h_q >= HsStart) && (h_q < HsEnd));
    vs_raw = !((v_q >= VsStart) && (v_q < VsEnd));
    fs_raw = (h_q == 11'd0) && (v_q == 11'd0);
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= 11'd0;
      v_q    <= 11'd0;
      req_q  <= 4'd0;
      hwin_q <= 11'd0;
      vwin_q <= 11'd0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      req_q  <= req_d;
      hwin_q <= hwin_d;
      vwin_q <= vwin_d;
    end
  end

  assign tft_req    = req_q;
  assign hcount_win = hwin_q;
  assign vcount_win = vwin_q;

  // One stage for the request register, DATA_LAT for the source, one for the RGB register.
  tft_sync_delay #(
    .Depth(2 + DATA_LAT)
  ) u_sync_delay (
    .clk_i (clk_vga),
    .rst_ni(rst_n),
    .hs_i  (hs_raw),
    .vs_i  (vs_raw),
    .de_i  (active),
    .fs_i  (fs_raw),
    .x_i   (h_q),
    .hs_o  (hs_dly),
    .vs_o  (vs_dly),
    .de_o  (de_dly),
    .fs_o  (fs_dly),
    .x_o   (x_dly)
  );

  assign tft_hs      = hs_dly;
  assign tft_vs      = vs_dly;
  assign tft_de      = de_dly;
  assign frame_start = fs_dly;

`ifdef TFT_TEST_PATTERN_EN
  localparam int unsigned BarW = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [10:0] bar_num;
  logic [2:0]  bar_idx;
  logic        unused_display;

  assign unused_display = ^display_data;

  always_comb begin
    bar_num = x_dly / 11'(BarW);
    bar_idx = (bar_num > 11'd7) ? 3'd7 : bar_num[2:0];
    tft_rgb = de_dly ? bar_colour(bar_idx) : BLACK;
  end
`else
  rgb565_t rgb_q;
  logic    unused_x;

  assign unused_x = ^x_dly;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= BLACK;
    end else begin
      rgb_q <= display_data;
    end
  end

  assign tft_rgb = de_dly ? rgb_q : BLACK;
`endif

endmodule

// File: tb/tb_tft_window_timing.sv
// Bench for tft_window_timing on a shrunken 40x24 raster with a window-aware pixel source.
module tb_tft_window_timing;

  localparam int HA = 40, HFP = 4, HS = 6, HBP = 5, HT = 55;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 3, VT = 31;
  localparam int FRAME = HT * VT;

  localparam int WX [4] = '{0, 0, 6, 30};
  localparam int WY [4] = '{0, 8, 2, 14};
  localparam int WW [4] = '{12, 8, 4, 20};
  localparam int WH [4] = '{8, 6, 4, 20};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] display_data = 16'h0000;
  logic [3:0]  tft_req;
  logic [10:0] hcount_win, vcount_win;
  logic        tft_hs, tft_vs, tft_de, frame_start;
  logic [15:0] tft_rgb;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int k;

  always #5 clk = ~clk;

  tft_window_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .WIN0_X(0), .WIN0_Y(0), .WIN0_W(12), .WIN0_H(8),
    .WIN1_X(0), .WIN1_Y(8), .WIN1_W(8), .WIN1_H(6),
    .WIN2_X(6), .WIN2_Y(2), .WIN2_W(4), .WIN2_H(4),
    .WIN3_X(30), .WIN3_Y(14), .WIN3_W(20), .WIN3_H(20),
    .DATA_LAT(1)
  ) dut (
    .clk_vga     (clk),
    .rst_n       (rst_n),
    .display_data(display_data),
    .tft_req     (tft_req),
    .hcount_win  (hcount_win),
    .vcount_win  (vcount_win),
    .tft_hs      (tft_hs),
    .tft_vs      (tft_vs),
    .tft_de      (tft_de),
    .tft_rgb     (tft_rgb),
    .frame_start (frame_start)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req"}, 32'(tft_req), 0);
    check({tag, "_hc"}, 32'(hcount_win), 0);
    check({tag, "_vc"}, 32'(vcount_win), 0);
    check({tag, "_hs"}, 32'(tft_hs), 1);
    check({tag, "_vs"}, 32'(tft_vs), 1);
    check({tag, "_de"}, 32'(tft_de), 0);
    check({tag, "_rgb"}, 32'(tft_rgb), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // Model: which window owns an absolute pixel, lowest index first, active area only.
  function automatic int win_of(int x, int y);
    if (x >= HA || y >= VA) return -1;
    for (int i = 0; i < 4; i++)
      if (x >= WX[i] && x < WX[i] + WW[i] && y >= WY[i] && y < WY[i] + WH[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pix_rgb(int x, int y);
    int w;
    logic [10:0] xs, ys;
    w  = win_of(x, y);
    xs = 11'(x);
    ys = 11'(y);
    if (x >= HA || y >= VA) return 16'h0000;
    if (w < 0) return 16'h5A5A;
    return {xs[4:0], ys[5:0], 5'(w + 1)};
  endfunction

  // Source mux stand-in: rebuilds absolute pixel from the grant, one cycle of read latency.
  function automatic logic [15:0] src_data(logic [3:0] req, logic [10:0] hx, logic [10:0] vy);
    int n;
    logic [10:0] ax, ay;
    case (req)
      4'b0000: return 16'h5A5A;
      4'b0001: n = 0;
      4'b0010: n = 1;
      4'b0100: n = 2;
      4'b1000: n = 3;
      default: return 16'hBAD0;
    endcase
    ax = hx + 11'(WX[n]);
    ay = vy + 11'(WY[n]);
    return {ax[4:0], ay[5:0], 5'(n + 1)};
  endfunction

  always @(posedge clk) display_data <= src_data(tft_req, hcount_win, vcount_win);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else k <= k + 1;
  end

  // Per-cycle compare: request stage shows pixel k-1, panel outputs show pixel k-3.
  always @(negedge clk) begin
    int p, x, y, w;
    if (!rst_n) begin
      check_reset_outputs("rst");
    end else begin
      if (k >= 1) begin
        p = k - 1;
        x = p % HT;
        y = (p / HT) % VT;
        w = win_of(x, y);
        check("req", 32'(tft_req), (w < 0) ? 0 : (1 << w));
        check("hcount", 32'(hcount_win), (w < 0) ? 0 : x - WX[w]);
        check("vcount", 32'(vcount_win), (w < 0) ? 0 : y - WY[w]);
      end else begin
        check("req0", 32'(tft_req), 0);
      end
      if (k >= 3) begin
        p = k - 3;
        x = p % HT;
        y = (p / HT) % VT;
        check("hs", 32'(tft_hs), (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1);
        check("vs", 32'(tft_vs), (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1);
        check("de", 32'(tft_de), (x < HA && y < VA) ? 1 : 0);
        check("fs", 32'(frame_start), (x == 0 && y == 0) ? 1 : 0);
        check("rgb", 32'(tft_rgb), 32'(pix_rgb(x, y)));
      end else begin
        check("hs0", 32'(tft_hs), 1);
        check("de0", 32'(tft_de), 0);
      end
    end
  end

  task automatic wait_index(int target, int offset, string tag);
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (k >= offset && (k - offset) % FRAME == target) return;
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  int hs_low, vs_low, de_cnt, fs_cnt, lat;

  initial begin
    #22;
    check_reset_outputs("init");
    rst_n = 1'b1;

    wait_index(44, 3, "hs_fall");
    check("hs_at_44", 32'(tft_hs), 0);
    wait_index(50, 3, "hs_rise");
    check("hs_at_50", 32'(tft_hs), 1);

    wait_index(3 * HT + 7, 1, "p7_3");
    check("ovl_req", 32'(tft_req), 4'b0001);
    check("ovl_hc", 32'(hcount_win), 7);
    check("ovl_vc", 32'(vcount_win), 3);

    wait_index(5 * HT + 10, 1, "p10_5");
    check("w0_req", 32'(tft_req), 4'b0001);
    check("w0_hc", 32'(hcount_win), 10);
    check("w0_vc", 32'(vcount_win), 5);
    wait_index(5 * HT + 10, 3, "rgb10_5");
    check("rgb10_5", 32'(tft_rgb), 16'h50A1);
    wait_index(5 * HT + 45, 3, "blank45_5");
    check("blank_de", 32'(tft_de), 0);
    check("blank_rgb", 32'(tft_rgb), 0);

    wait_index(8 * HT + 0, 1, "p0_8");
    check("w1_req", 32'(tft_req), 4'b0010);
    check("w1_hc", 32'(hcount_win), 0);
    check("w1_vc", 32'(vcount_win), 0);

    wait_index(23 * HT + 35, 1, "p35_23");
    check("w3_req", 32'(tft_req), 4'b1000);
    check("w3_hc", 32'(hcount_win), 5);
    check("w3_vc", 32'(vcount_win), 9);
    wait_index(23 * HT + 39, 1, "p39_23");
    check("clip_hc", 32'(hcount_win), 9);
    check("clip_vc", 32'(vcount_win), 9);
    wait_index(23 * HT + 40, 1, "p40_23");
    check("clip_req", 32'(tft_req), 0);

    wait_index(0, 3, "frame2");
    hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!tft_hs) hs_low++;
      if (!tft_vs) vs_low++;
      if (tft_de) de_cnt++;
      if (frame_start) fs_cnt++;
      @(negedge clk);
    end
    check("hs_low_2f", 32'(hs_low), 372);
    check("vs_low_2f", 32'(vs_low), 220);
    check("de_2f", 32'(de_cnt), 1920);
    check("fs_2f", 32'(fs_cnt), 2);

    wait_index(20 * HT + 30, 0, "mid_frame");
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (tft_de) break;
    end
    check("de_latency", 32'(lat), 3);
    check("first_fs", 32'(frame_start), 1);

    repeat (200) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
